mem_bist: RTL and testbench



---
 rtl/mem_bist.sv | 151 +++++++++++++++
 tb/tb_mem_bist.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// Memory BIST initiator: four-pass write/read-compare (P, ~P with P(a) = seed ^ a)
// over every location, reporting miscompare count, first failing address and pass flag.
module mem_bist #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [6:0]        err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  // Memory handshake: strobes are single-cycle commands with no ready; a write lands
  // at the edge closing WR, and read data is valid at the edge closing RWAIT.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_RWAIT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // phase: 0 = W0, 1 = R0, 2 = W1, 3 = R1; bit 1 selects the inverted pattern
  state_t            state, state_n;
  logic [ADDR_W-1:0] a, a_n;
  logic [1:0]        phase, phase_n;
  logic [DATA_W-1:0] seed_q, seed_n;
  logic [6:0]        err_n;
  logic [ADDR_W-1:0] ffa_n, mem_addr_n;
  logic              pass_n, busy_n, done_n, mem_read_n, mem_write_n;
  logic [DATA_W-1:0] mem_wdata_n, exp_data;

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic inv);
    return (s ^ DATA_W'(addr)) ^ {DATA_W{inv}};
  endfunction

  assign dbg_state = state;
  assign exp_data  = pattern(seed_q, a, phase[1]);

  always_comb begin
    state_n = state;
    a_n     = a;
    phase_n = phase;
    seed_n  = seed_q;
    err_n   = err_count;
    ffa_n   = first_fail_addr;
    pass_n  = pass;
    case (state)
      S_IDLE: begin
        if (start) begin
          seed_n  = seed;
          err_n   = '0;
          ffa_n   = '0;
          pass_n  = 1'b0;
          a_n     = '0;
          phase_n = 2'd0;
          state_n = S_WR;
        end
      end
      S_WR: begin
        if (a == LAST) begin
          a_n     = '0;
          phase_n = phase + 2'd1;
          state_n = S_RD;
        end else begin
          a_n = a + 1'b1;
        end
      end
      S_RD: state_n = S_RWAIT;
      S_RWAIT: begin
        if (mem_rdata != exp_data) begin
          err_n = err_count + 7'd1;
          if (err_count == 7'd0) ffa_n = a;
        end
        if (a == LAST) begin
          a_n = '0;
          if (phase == 2'd3) begin
            state_n = S_DONE;
          end else begin
            phase_n = phase + 2'd1;
            state_n = S_WR;
          end
        end else begin
          a_n     = a + 1'b1;
          state_n = S_RD;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_DONE) pass_n = (err_n == 7'd0);

    // Outputs are registered, so they are derived from the upcoming state.
    busy_n      = (state_n == S_WR) || (state_n == S_RD) || (state_n == S_RWAIT);
    done_n      = (state_n == S_DONE);
    mem_write_n = (state_n == S_WR);
    mem_read_n  = (state_n == S_RD);
    mem_addr_n  = busy_n ? a_n : '0;
    mem_wdata_n = mem_write_n ? pattern(seed_n, a_n, phase_n[1]) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      a               <= '0;
      phase           <= 2'd0;
      seed_q          <= '0;
      err_count       <= '0;
      first_fail_addr <= '0;
      pass            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      state           <= state_n;
      a               <= a_n;
      phase           <= phase_n;
      seed_q          <= seed_n;
      err_count       <= err_n;
      first_fail_addr <= ffa_n;
      pass            <= pass_n;
      busy            <= busy_n;
      done            <= done_n;
      mem_read        <= mem_read_n;
      mem_write       <= mem_write_n;
      mem_addr        <= mem_addr_n;
      mem_wdata       <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: behavioural 32x8 memory with injectable read faults, a
// loop-based error model, protocol monitor and directed plus randomized tests.
module tb_mem_bist;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       busy, done, pass, mem_read, mem_write;
  logic [6:0] err_count;
  logic [4:0] first_fail_addr, mem_addr;
  logic [7:0] mem_wdata, data_out;
  logic [2:0] dbg_state;

  logic [7:0] mem [DEPTH];
  int fault_mode = 0;  // 0 none, 1 stuck-at-0 bit, 2 flip mask at one address
  int fault_bit = 0;
  logic [4:0] fault_addr = 5'd0;
  logic [7:0] fault_mask = 8'h00;

  int checks = 0;
  int errors = 0;
  int proto_viol = 0;

  mem_bist #(.ADDR_W(5), .DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(data_out),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] apply_fault(input logic [7:0] v, input logic [4:0] a);
    case (fault_mode)
      1:       return v & ~(8'd1 << fault_bit);
      2:       return (a == fault_addr) ? (v ^ fault_mask) : v;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) data_out <= apply_fault(mem[mem_addr], mem_addr);
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) proto_viol++;
    if (!busy && (mem_read || mem_write)) proto_viol++;
    if (int'(mem_addr) > DEPTH - 1) proto_viol++;
    if (!mem_write && mem_wdata != 8'h00) proto_viol++;
  end

  // Reference: every location holds what was written, so a read returns the fault
  // applied to the expected pattern; count the differences in R0 then R1 order.
  task automatic model(input logic [7:0] s, output int errs, output int ffa);
    errs = 0;
    ffa = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        logic [7:0] expv;
        expv = (s ^ 8'(a)) ^ ((p == 1) ? 8'hFF : 8'h00);
        if (apply_fault(expv, 5'(a)) != expv) begin
          if (errs == 0) ffa = a;
          errs++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
    end
  endtask

  task automatic run_test(input logic [7:0] s, input bit hold, output int cycles);
    @(negedge clk);
    seed_in = s;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    seed_in = 8'($urandom);
    chk("busy_after_start", busy, 1);
    wait_done(cycles);
  endtask

  task automatic check_result(input string tag, input int exp_err, input int exp_ffa);
    chk({tag, "_err"}, err_count, exp_err);
    chk({tag, "_ffa"}, first_fail_addr, exp_ffa);
    chk({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
    chk({tag, "_busy_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, dbg_state, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_ffa"}, first_fail_addr, 0);
    chk({tag, "_strobes"}, {mem_read, mem_write}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int cyc, bad, e_err, e_ffa;
    logic [7:0] s;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Good memory, seed 0: memory ends holding ~a
    run_test(8'h00, 1'b0, cyc);
    chk("good_cycles", cyc, 192);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== ~8'(a)) bad++;
    chk("good_mem_final", bad, 0);
    check_result("good", 0, 0);

    // Stuck-at-0 on data bit 0 with seed 0xA5
    fault_mode = 1; fault_bit = 0;
    run_test(8'hA5, 1'b0, cyc);
    chk("stuck_cycles", cyc, 192);
    check_result("stuck", 32, 0);

    // Bit 7 flipped on reads of address 17 with seed 0x3C
    fault_mode = 2; fault_addr = 5'd17; fault_mask = 8'h80;
    run_test(8'h3C, 1'b0, cyc);
    chk("flip17_cycles", cyc, 192);
    check_result("flip17", 2, 17);

    // Reset in the middle of W1
    fault_mode = 0;
    @(negedge clk);
    seed_in = 8'h5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (119) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_write", mem_write, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    run_test(8'h5A, 1'b0, cyc);
    chk("after_reset_cycles", cyc, 192);
    check_result("after_reset", 0, 0);

    // start held high: ignored while busy and in DONE, re-accepted from IDLE
    run_test(8'hC3, 1'b1, cyc);
    chk("held_cycles", cyc, 192);
    check_result("held", 0, 0);
    @(posedge clk); #1;
    chk("held_reaccept_busy", busy, 1);
    start = 1'b0;
    wait_done(cyc);
    chk("held_second_cycles", cyc, 192);
    check_result("held2", 0, 0);

    // Randomized seeds and faults against the reference model
    for (int i = 0; i < 5; i++) begin
      s = 8'($urandom);
      fault_mode = $urandom_range(0, 2);
      fault_bit = $urandom_range(0, 7);
      fault_addr = 5'($urandom_range(0, DEPTH - 1));
      fault_mask = 8'(1 << $urandom_range(0, 7)) | 8'($urandom);
      model(s, e_err, e_ffa);
      run_test(s, 1'b0, cyc);
      chk("rand_cycles", cyc, 192);
      check_result("rand", e_err, e_ffa);
    end

    chk("protocol_violations", proto_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
